smem_output_collector: RTL and testbench

Consumer end of the per-PE result output handshake (output_request / output_permit / output_data / output_valid / output_finish) driven by each SMEM result-queue block. It arbitrates round-robin among NUM_PE requesting PEs and grants permit to one PE at a time. It captures that PE's 512-bit lines into an internal FIFO and drains the FIFO to the host write channel at consecutive cache-line addresses. It generates the shared pipeline stall used as back-pressure and raises done once every PE has finished and all writes have retired.

---
 rtl/smem_out_pkg.sv | 19 +
 rtl/smem_out_fifo.sv | 52 +++++
 rtl/smem_output_collector.sv | 181 ++++++++++++++++++
 tb/tb_smem_output_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_out_pkg.sv
// Shared types and constants for the SMEM result output collector.
package smem_out_pkg;

  localparam int unsigned CL = 512;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StGrant,
    StDrain,
    StDone
  } state_e;

  // Round-robin pointer width; at least one bit even for a single PE.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smem_out_fifo.sv
// Synchronous line FIFO: registered occupancy, head of queue visible combinationally.
module smem_out_fifo
  import smem_out_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = CL,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic [CntW-1:0]  o_count
);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count < CntW'(Depth));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/smem_output_collector.sv
// Round-robin collector of per-PE result lines into a FIFO drained to the host write channel.
// Define SMEM_OUT_PERF_EN to add stall / write back-pressure cycle counters.
module smem_output_collector
  import smem_out_pkg::*;
#(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PE-1:0]      pe_output_request,
  output logic [NUM_PE-1:0]      pe_output_permit,
  input  logic [NUM_PE*CL-1:0]   pe_output_data,
  input  logic [NUM_PE-1:0]      pe_output_valid,
  input  logic [NUM_PE-1:0]      pe_output_finish,
  output logic                   stall,
  input  logic [ADDR_WIDTH-1:0]  wr_base_addr,
  output logic                   wr_req_valid,
  output logic [ADDR_WIDTH-1:0]  wr_req_addr,
  output logic [CL-1:0]          wr_req_data,
  input  logic                   wr_req_ready,
  output logic [31:0]            lines_written,
  output logic                   done
`ifdef SMEM_OUT_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_wr_bp_cycles
`endif
);

  localparam int unsigned PtrW = ptr_w(NUM_PE);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e                r_state;
  logic [NUM_PE-1:0]     r_permit;
  logic [NUM_PE-1:0]     r_served;
  logic [PtrW-1:0]       r_rr;
  logic [PtrW-1:0]       r_gidx;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_lines;

  logic [CntW-1:0]       w_count;
  logic [CL-1:0]         w_head;
  logic [CL-1:0]         w_g_data;
  logic [NUM_PE-1:0]     w_eligible;
  logic [PtrW-1:0]       w_pick_idx;
  logic                  w_pick_found;
  int unsigned           w_j;
  logic                  w_stall;
  logic                  w_g_valid;
  logic                  w_g_finish;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_valid;

  // Capture is held off one entry early so a stalled PE never overruns the FIFO.
  assign w_stall    = w_count >= CntW'(FIFO_DEPTH - 1);
  assign w_g_valid  = |(pe_output_valid & r_permit);
  assign w_g_finish = |(pe_output_finish & r_permit);
  assign w_push     = (r_state == StGrant) && w_g_valid && !w_stall;
  assign w_wr_valid = (r_state != StIdle) && (w_count != '0);
  assign w_pop      = w_wr_valid && wr_req_ready;

  always_comb begin
    w_g_data = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (r_permit[i]) w_g_data = pe_output_data[i*CL +: CL];
    end
  end

  // First eligible PE at or after the round-robin pointer, wrapping.
  always_comb begin
    w_eligible   = pe_output_request & ~r_served;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_j          = 0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      w_j = (32'(r_rr) + k) % NUM_PE;
      if (!w_pick_found && w_eligible[w_j[PtrW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_j[PtrW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_permit <= '0;
      r_served <= '0;
      r_rr     <= '0;
      r_gidx   <= '0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: r_state <= StArb;
        StArb: begin
          if (&r_served) begin
            r_state <= StDrain;
          end else if (w_pick_found) begin
            r_permit             <= '0;
            r_permit[w_pick_idx] <= 1'b1;
            r_gidx               <= w_pick_idx;
            r_state              <= StGrant;
          end
        end
        StGrant: begin
          if (w_g_finish && !w_stall) begin
            r_served[r_gidx] <= 1'b1;
            r_permit         <= '0;
            r_rr             <= (r_gidx == PtrW'(NUM_PE - 1)) ? '0 : r_gidx + 1'b1;
            r_state          <= StArb;
          end
        end
        StDrain: begin
          if (!w_wr_valid && (w_count == '0)) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: r_done <= 1'b1;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_lines <= '0;
    end else if (r_state == StIdle) begin
      r_addr <= wr_base_addr;
    end else if (w_pop) begin
      r_addr  <= r_addr + 1'b1;
      r_lines <= r_lines + 32'd1;
    end
  end

  smem_out_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CL)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_g_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

`ifdef SMEM_OUT_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_bp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_bp    <= '0;
    end else begin
      if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_wr_valid && !wr_req_ready && (r_perf_bp != '1)) r_perf_bp <= r_perf_bp + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_wr_bp_cycles = r_perf_bp;
`endif

  assign pe_output_permit = r_permit;
  assign stall            = w_stall;
  assign wr_req_valid     = w_wr_valid;
  assign wr_req_addr      = r_addr;
  // Data bus reads as zero whenever no request is presented.
  assign wr_req_data      = w_wr_valid ? w_head : '0;
  assign lines_written    = r_lines;
  assign done             = r_done;

endmodule

// File: tb/tb_smem_output_collector.sv
// Scenario table plus hand sequences for smem_output_collector, checked against a line-order model.
module tb_smem_output_collector;

  localparam int NPE   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int CLW   = 512;
  localparam int MAXL  = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [NPE-1:0]     req, permit, valid, finish;
  logic [NPE*CLW-1:0] data;
  logic               stall, wr_valid, wr_ready, done;
  logic [AW-1:0]      base, wr_addr;
  logic [CLW-1:0]     wr_data;
  logic [31:0]        lines_written;
`ifdef SMEM_OUT_PERF_EN
  logic [31:0]        perf_stall, perf_bp;
`endif

  smem_output_collector #(
    .NUM_PE     (NPE),
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pe_output_request (req),
    .pe_output_permit  (permit),
    .pe_output_data    (data),
    .pe_output_valid   (valid),
    .pe_output_finish  (finish),
    .stall             (stall),
    .wr_base_addr      (base),
    .wr_req_valid      (wr_valid),
    .wr_req_addr       (wr_addr),
    .wr_req_data       (wr_data),
    .wr_req_ready      (wr_ready),
    .lines_written     (lines_written),
    .done              (done)
`ifdef SMEM_OUT_PERF_EN
    ,
    .perf_stall_cycles (perf_stall),
    .perf_wr_bp_cycles (perf_bp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NPE-1:0]      req;
    logic [NPE-1:0][7:0] nl;
    logic [NPE-1:0]      fl;
    logic [AW-1:0]       base;
    int                  ready_pct;
    int                  exp_lines;
    logic                exp_done;
  } scn_t;

  scn_t           tbl [6];
  scn_t           s_hold, s_rst;
  logic [CLW-1:0] lines [NPE][MAXL];
  int             nl [NPE], pos [NPE];
  bit             en [NPE], fin_last [NPE];
  logic [CLW-1:0] exp_q [$];
  int             exp_order [$], grants [$];
  logic [AW-1:0]  exp_addr;
  logic [NPE-1:0] prev_permit;
  logic [AW-1:0]  hold_addr;
  logic [CLW-1:0] hold_data;
  int             occ, nwr, ready_pct;
  int             errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [CLW-1:0] act, input logic [CLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // PE behaviour: present lines in order (granted or not), finish once all lines are out.
  task automatic drive();
    for (int i = 0; i < NPE; i++) begin
      req[i]   = en[i];
      valid[i] = pos[i] < nl[i];
      data[i*CLW +: CLW] = (pos[i] < nl[i]) ? lines[i][pos[i]] : '0;
      finish[i] = en[i] && ((pos[i] >= nl[i]) || (fin_last[i] && (pos[i] == nl[i] - 1)));
    end
    wr_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic step();
    logic [NPE-1:0] acc;
    @(negedge clk);
    chk("stall", stall, occ >= DEPTH - 1);
    chk("permit_onehot", $countones(permit) <= 1, 1'b1);
    if (permit != '0 && permit != prev_permit) begin
      for (int i = 0; i < NPE; i++) if (permit[i]) grants.push_back(i);
    end
    prev_permit = permit;
    if (wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write: got addr %0h expected no write", wr_addr);
      end else begin
        chk("wr_addr", wr_addr, exp_addr);
        chk("wr_data", wr_data, exp_q.pop_front());
      end
      exp_addr++;
      occ--;
      nwr++;
    end
    acc = permit & valid & {NPE{!stall}};
    for (int i = 0; i < NPE; i++) if (acc[i]) occ++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NPE; i++) if (acc[i]) pos[i]++;
    drive();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    occ         = 0;
    nwr         = 0;
    prev_permit = '0;
    grants.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_permit", permit, '0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_lines_written", lines_written, '0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Expected output: PEs served round-robin from index 0, each contributing its lines in order.
  task automatic setup(input scn_t s);
    bit srv [NPE];
    int rr, j;
    bit found;
    exp_q.delete();
    exp_order.delete();
    for (int i = 0; i < NPE; i++) begin
      en[i]       = s.req[i];
      nl[i]       = int'(s.nl[i]);
      fin_last[i] = s.fl[i];
      pos[i]      = 0;
      srv[i]      = 1'b0;
      for (int l = 0; l < nl[i]; l++)
        for (int w = 0; w < CLW / 32; w++) lines[i][l][w*32 +: 32] = $urandom;
    end
    rr = 0;
    for (int n = 0; n < NPE; n++) begin
      found = 1'b0;
      for (int k = 0; k < NPE; k++) begin
        j = (rr + k) % NPE;
        if (!found && en[j] && !srv[j]) begin
          found  = 1'b1;
          srv[j] = 1'b1;
          exp_order.push_back(j);
          rr = (j + 1) % NPE;
        end
      end
    end
    foreach (exp_order[o])
      for (int l = 0; l < nl[exp_order[o]]; l++) exp_q.push_back(lines[exp_order[o]][l]);
    exp_addr  = s.base;
    base      = s.base;
    ready_pct = s.ready_pct;
    drive();
    do_reset();
  endtask

  task automatic run_scn(input scn_t s);
    int cyc;
    cyc = 0;
    while (cyc < 3000 && !(nwr >= s.exp_lines && (!s.exp_done || done))) begin
      step();
      cyc++;
    end
    if (!s.exp_done) repeat (10) step();
    chk("write_count", nwr, s.exp_lines);
    chk("lines_written", lines_written, s.exp_lines);
    chk("done", done, s.exp_done);
    chk("grant_count", grants.size(), exp_order.size());
    foreach (exp_order[o]) if (o < grants.size()) chk("grant_order", grants[o], exp_order[o]);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    reset    = 1'b1;
    wr_ready = 1'b0;
    tbl[0] = '{req: 4'b1111, nl: {8'd3, 8'd3, 8'd3, 8'd3}, fl: 4'b0000, base: 32'h0000_1000,
               ready_pct: 100, exp_lines: 12, exp_done: 1'b1};
    tbl[1] = '{req: 4'b0100, nl: {8'd0, 8'd4, 8'd0, 8'd0}, fl: 4'b0000, base: 32'hFFFF_FFFE,
               ready_pct: 100, exp_lines: 4, exp_done: 1'b0};
    tbl[2] = '{req: 4'b1111, nl: {8'd2, 8'd7, 8'd0, 8'd5}, fl: 4'b0000, base: 32'h0000_0040,
               ready_pct: 50, exp_lines: 14, exp_done: 1'b1};
    tbl[3] = '{req: 4'b1111, nl: {8'd6, 8'd6, 8'd6, 8'd6}, fl: 4'b1010, base: 32'h7FFF_FFF0,
               ready_pct: 30, exp_lines: 24, exp_done: 1'b1};
    tbl[4] = '{req: 4'b1011, nl: {8'd3, 8'd4, 8'd9, 8'd2}, fl: 4'b0001, base: 32'h0001_0000,
               ready_pct: 70, exp_lines: 14, exp_done: 1'b0};
    tbl[5] = '{req: 4'b1111, nl: {8'd1, 8'd1, 8'd2, 8'd1}, fl: 4'b0010, base: 32'h0000_0100,
               ready_pct: 100, exp_lines: 5, exp_done: 1'b1};
    s_hold = '{req: 4'b0001, nl: {8'd0, 8'd0, 8'd0, 8'd20}, fl: 4'b0000, base: 32'h0000_A000,
               ready_pct: 0, exp_lines: 20, exp_done: 1'b0};
    s_rst  = '{req: 4'b0001, nl: {8'd0, 8'd0, 8'd0, 8'd20}, fl: 4'b0000, base: 32'h0000_5000,
               ready_pct: 100, exp_lines: 20, exp_done: 1'b0};

    for (int t = 0; t < 6; t++) begin
      setup(tbl[t]);
      run_scn(tbl[t]);
    end

    // Back-pressure: FIFO fills to DEPTH-1 and the head stays put while ready is low.
    setup(s_hold);
    repeat (40) step();
    chk("captured_at_stall", pos[0], DEPTH - 1);
    chk("stall_held", stall, 1'b1);
    hold_addr = wr_addr;
    hold_data = wr_data;
    repeat (5) begin
      step();
      chk("hold_valid", wr_valid, 1'b1);
      chk("hold_addr", wr_addr, hold_addr);
      chk("hold_data", wr_data, hold_data);
    end
    chk("hold_head_addr", hold_addr, s_hold.base);
    ready_pct = 100;
    run_scn(s_hold);

    // Reset while granted with 7 lines queued.
    setup(s_rst);
    repeat (5) step();
    ready_pct = 0;
    cyc = 0;
    while (occ != 7 && cyc < 60) begin
      step();
      cyc++;
    end
    chk("pre_rst_occ", occ, 7);
    chk("pre_rst_permit", permit, 4'b0001);
    chk("pre_rst_lines", lines_written, nwr);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_permit", permit, '0);
    chk("mid_rst_wr_valid", wr_valid, 1'b0);
    chk("mid_rst_lines", lines_written, '0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
